uart_rx_frame_ctrl: RTL and testbench

Frame controller that sits directly behind the UART byte receiver and sequences its byte stream into checked packets. It consumes one-cycle byte strobes, hunts for a sync byte, then collects a length byte, the payload and a checksum. A good frame is stored and presented to the consumer through a valid/ready handshake with random-access payload read. Bad length, bad checksum, inter-byte timeout and overrun are each reported as one-cycle error pulses.

---
 rtl/uart_rx_frame_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_uart_rx_frame_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_frame_ctrl.sv
// uart_rx_frame_ctrl
//   Sequences the UART receiver's byte strobes into checked packets:
//   SYNC_BYTE, length (1..MAX_LEN), payload, 8-bit additive checksum.
//   The checksum covers the length byte and the payload.
//   A good frame is held until the consumer handshakes it. During that
//   time the payload can be read at random addresses.
//
// Ports
//   clk, rst_n           single clock, asynchronous active-low reset
//   i_rx_dv, i_rx_byte   one-cycle byte strobe and data from the receiver
//   o_frame_valid        stored frame available (HOLD state)
//   i_frame_ready        consumer accepts the stored frame
//   o_frame_len          payload length of the stored frame (0 when none held)
//   i_rd_addr, o_rd_data combinational payload read; 0 beyond o_frame_len
//   o_err, o_err_code    one-cycle error pulse:
//                        0 overrun, 1 bad length, 2 bad checksum, 3 timeout
//   o_busy               high whenever the controller is not IDLE
module uart_rx_frame_ctrl #(
  parameter int         CLKS_PER_BIT = 87,
  parameter int         MAX_LEN      = 16,
  parameter logic [7:0] SYNC_BYTE    = 8'hAA,
  parameter int         TIMEOUT_BITS = 20,
  localparam int        AW           = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_rx_dv,
  input  logic [7:0]    i_rx_byte,
  output logic          o_frame_valid,
  input  logic          i_frame_ready,
  output logic [7:0]    o_frame_len,
  input  logic [AW-1:0] i_rd_addr,
  output logic [7:0]    o_rd_data,
  output logic          o_err,
  output logic [1:0]    o_err_code,
  output logic          o_busy
);

  localparam int         TIMEOUT_CYC = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int         CW          = $clog2(TIMEOUT_CYC + 1);
  localparam logic [7:0] MAX_LEN_B   = 8'(MAX_LEN);

  localparam logic [1:0] ERR_OVR = 2'd0;
  localparam logic [1:0] ERR_LEN = 2'd1;
  localparam logic [1:0] ERR_CHK = 2'd2;
  localparam logic [1:0] ERR_TMO = 2'd3;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    GET_LEN  = 3'd1,
    GET_DATA = 3'd2,
    GET_CHK  = 3'd3,
    HOLD     = 3'd4
  } state_t;

  state_t         r_state;
  logic [7:0]     r_len;
  logic [7:0]     r_frame_len;
  logic [7:0]     r_sum;
  logic [7:0]     r_idx;
  logic [CW-1:0]  r_cnt;
  logic           r_valid;
  logic           r_err;
  logic [1:0]     r_err_code;
  logic           r_busy;
  logic [7:0]     r_buf [MAX_LEN];

  logic           w_expire;
  logic           w_buf_we;

  // Expiry is ignored when a byte lands on the same edge.
  assign w_expire = (r_cnt == CW'(TIMEOUT_CYC - 1));
  assign w_buf_we = (r_state == GET_DATA) && i_rx_dv;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_len       <= 8'd0;
      r_frame_len <= 8'd0;
      r_sum       <= 8'd0;
      r_idx       <= 8'd0;
      r_cnt       <= '0;
      r_valid     <= 1'b0;
      r_err       <= 1'b0;
      r_err_code  <= 2'd0;
      r_busy      <= 1'b0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        IDLE: begin
          r_sum <= 8'd0;
          r_idx <= 8'd0;
          r_cnt <= '0;
          if (i_rx_dv && (i_rx_byte == SYNC_BYTE)) begin
            r_state <= GET_LEN;
            r_busy  <= 1'b1;
          end
        end

        GET_LEN: begin
          if (i_rx_dv) begin
            r_cnt <= '0;
            if ((i_rx_byte == 8'd0) || (i_rx_byte > MAX_LEN_B)) begin
              r_err      <= 1'b1;
              r_err_code <= ERR_LEN;
              r_state    <= IDLE;
              r_busy     <= 1'b0;
            end else begin
              r_len   <= i_rx_byte;
              r_sum   <= i_rx_byte;
              r_state <= GET_DATA;
            end
          end else if (w_expire) begin
            r_err      <= 1'b1;
            r_err_code <= ERR_TMO;
            r_state    <= IDLE;
            r_busy     <= 1'b0;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end

        GET_DATA: begin
          if (i_rx_dv) begin
            r_cnt <= '0;
            r_sum <= r_sum + i_rx_byte;
            r_idx <= r_idx + 8'd1;
            if (r_idx == (r_len - 8'd1))
              r_state <= GET_CHK;
          end else if (w_expire) begin
            r_err      <= 1'b1;
            r_err_code <= ERR_TMO;
            r_state    <= IDLE;
            r_busy     <= 1'b0;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end

        GET_CHK: begin
          if (i_rx_dv) begin
            r_cnt <= '0;
            if (i_rx_byte == r_sum) begin
              r_state     <= HOLD;
              r_valid     <= 1'b1;
              r_frame_len <= r_len;
            end else begin
              r_err      <= 1'b1;
              r_err_code <= ERR_CHK;
              r_state    <= IDLE;
              r_busy     <= 1'b0;
            end
          end else if (w_expire) begin
            r_err      <= 1'b1;
            r_err_code <= ERR_TMO;
            r_state    <= IDLE;
            r_busy     <= 1'b0;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end

        HOLD: begin
          // No room for a second frame: any byte now is lost, even on
          // the handshake edge.
          if (i_rx_dv) begin
            r_err      <= 1'b1;
            r_err_code <= ERR_OVR;
          end
          if (i_frame_ready) begin
            r_state     <= IDLE;
            r_valid     <= 1'b0;
            r_frame_len <= 8'd0;
            r_busy      <= 1'b0;
          end
        end

        default: begin
          r_state <= IDLE;
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Payload store: not reset, only written while collecting, so it is
  // frozen in HOLD.
  always_ff @(posedge clk) begin
    if (w_buf_we)
      r_buf[r_idx[AW-1:0]] <= i_rx_byte;
  end

  assign o_frame_valid = r_valid;
  assign o_frame_len   = r_frame_len;
  assign o_err         = r_err;
  assign o_err_code    = r_err_code;
  assign o_busy        = r_busy;
  assign o_rd_data     = (8'(i_rd_addr) < r_frame_len) ? r_buf[i_rd_addr] : 8'h00;

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Bench for uart_rx_frame_ctrl. It uses a byte-stream model: the bytes
// seen after a sync are collected in a queue. A frame is judged once the
// queue holds length+2 bytes. Timeout is a count of quiet edges since the
// last accepted byte. Directed cases pin the model with literal values.
// Randomized frame streams are then checked against the model every cycle.
module tb_uart_rx_frame_ctrl;
  localparam int MAX_LEN = 16;
  localparam int TO_CYC  = 20 * 87;

  logic       clk, rst_n;
  logic       i_rx_dv;
  logic [7:0] i_rx_byte;
  logic       o_frame_valid;
  logic       i_frame_ready;
  logic [7:0] o_frame_len;
  logic [3:0] i_rd_addr;
  logic [7:0] o_rd_data;
  logic       o_err;
  logic [1:0] o_err_code;
  logic       o_busy;

  uart_rx_frame_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .i_rx_dv(i_rx_dv), .i_rx_byte(i_rx_byte),
    .o_frame_valid(o_frame_valid), .i_frame_ready(i_frame_ready),
    .o_frame_len(o_frame_len), .i_rd_addr(i_rd_addr), .o_rd_data(o_rd_data),
    .o_err(o_err), .o_err_code(o_err_code), .o_busy(o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass = 0;
  int n_tot  = 0;

  // Model state
  bit          m_in;
  bit          m_held;
  int unsigned q[$];
  int unsigned m_pay[$];
  int          m_idle;
  bit          m_err;
  int          m_code;

  task automatic chk(input string name, input int act, input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                  name, act, act, exp, exp, $time);
  endtask

  task automatic model_clear();
    m_in = 0; m_held = 0; q.delete(); m_pay.delete(); m_idle = 0; m_err = 0; m_code = 0;
  endtask

  task automatic model_step(input bit dv, input int unsigned b, input bit rdy);
    int unsigned s;
    m_err = 0;
    if (m_held) begin
      if (dv) begin m_err = 1; m_code = 0; end
      if (rdy) m_held = 0;
    end else if (m_in) begin
      if (dv) begin
        m_idle = 0;
        q.push_back(b);
        if (q.size() == 1 && (b == 0 || b > MAX_LEN)) begin
          m_err = 1; m_code = 1; m_in = 0; q.delete();
        end else if (q.size() == q[0] + 2) begin
          s = 0;
          for (int i = 0; i < q.size() - 1; i++) s += q[i];
          if ((s % 256) == b) begin
            m_held = 1;
            m_pay.delete();
            for (int i = 1; i <= q[0]; i++) m_pay.push_back(q[i]);
          end else begin
            m_err = 1; m_code = 2;
          end
          m_in = 0; q.delete();
        end
      end else begin
        m_idle++;
        if (m_idle == TO_CYC) begin
          m_err = 1; m_code = 3; m_in = 0; q.delete();
        end
      end
    end else if (dv && b == 8'hAA) begin
      m_in = 1; m_idle = 0;
    end
  endtask

  task automatic compare();
    int unsigned exp_rd;
    chk("busy", o_busy, int'(m_in || m_held));
    chk("valid", o_frame_valid, int'(m_held));
    chk("err", o_err, int'(m_err));
    if (m_err && o_err) chk("err_code", o_err_code, m_code);
    if (m_held) begin
      chk("frame_len", o_frame_len, m_pay.size());
      exp_rd = (i_rd_addr < m_pay.size()) ? m_pay[i_rd_addr] : 0;
      chk("rd_data", o_rd_data, exp_rd);
    end
  endtask

  // One clock: drive at negedge, model steps on posedge, compare at negedge.
  task automatic cycle(input bit dv, input logic [7:0] b, input bit rdy);
    i_rx_dv = dv; i_rx_byte = dv ? b : 8'($urandom); i_frame_ready = rdy;
    i_rd_addr = 4'($urandom_range(0, 15));
    @(posedge clk);
    model_step(dv, b, rdy);
    @(negedge clk);
    compare();
  endtask

  task automatic send(input logic [7:0] b); cycle(1'b1, b, 1'b0); endtask
  task automatic quiet(input int n); for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 1'b0); endtask

  task automatic peek(input int a, input int exp);
    i_rd_addr = 4'(a);
    #1;
    chk($sformatf("rd_data[%0d]", a), o_rd_data, exp);
  endtask

  task automatic send_frame(input logic [7:0] len, input logic [7:0] d0);
    logic [7:0] s;
    send(8'hAA); send(len); s = len;
    for (int i = 0; i < len; i++) begin send(d0 + 8'(i)); s = s + d0 + 8'(i); end
    send(s);
  endtask

  initial begin
    int unsigned stream[$];
    logic [7:0] s, l;
    rst_n = 1'b0; i_rx_dv = 0; i_rx_byte = 0; i_frame_ready = 0; i_rd_addr = 0;
    model_clear();
    @(negedge clk);
    chk("rst_valid", o_frame_valid, 0); chk("rst_len", o_frame_len, 0);
    chk("rst_err", o_err, 0); chk("rst_code", o_err_code, 0);
    chk("rst_busy", o_busy, 0); peek(0, 0);
    @(negedge clk); rst_n = 1'b1;
    quiet(2);

    // Good frame, held for 10 cycles, then handshake.
    send(8'hAA); send(8'h03); send(8'h11); send(8'h22); send(8'h33);
    chk("good_busy_pre", o_busy, 1); chk("good_valid_pre", o_frame_valid, 0);
    send(8'h69);
    chk("good_valid", o_frame_valid, 1); chk("good_len", o_frame_len, 3);
    peek(0, 8'h11); peek(1, 8'h22); peek(2, 8'h33); peek(3, 8'h00);
    for (int i = 0; i < 10; i++) begin quiet(1); chk("good_hold", o_frame_valid, 1); end
    cycle(1'b0, 8'h00, 1'b1);
    chk("good_release", o_frame_valid, 0); chk("good_busy_post", o_busy, 0);

    // Garbage then frame.
    send(8'h55); chk("garb_err55", o_err, 0); chk("garb_busy55", o_busy, 0);
    send(8'h00); chk("garb_err00", o_err, 0);
    send(8'hAA); send(8'h01); send(8'h5A); send(8'h5B);
    chk("garb_valid", o_frame_valid, 1); chk("garb_len", o_frame_len, 1);
    peek(0, 8'h5A); peek(1, 8'h00);
    cycle(1'b0, 8'h00, 1'b1);

    // Error frames, each followed by a good frame.
    send(8'hAA); send(8'h00);
    chk("len0_err", o_err, 1); chk("len0_code", o_err_code, 1); chk("len0_busy", o_busy, 0);
    quiet(1); chk("len0_pulse", o_err, 0);
    send(8'hAA); send(8'h11);
    chk("len17_err", o_err, 1); chk("len17_code", o_err_code, 1);
    send(8'hAA); send(8'h02); send(8'h01); send(8'h02); send(8'h00);
    chk("chk_err", o_err, 1); chk("chk_code", o_err_code, 2);
    send(8'hAA); send(8'h01); send(8'h5A); send(8'h5B);
    chk("recov_valid", o_frame_valid, 1); peek(0, 8'h5A);
    cycle(1'b0, 8'h00, 1'b1);

    // Timeout: 1740 quiet edges after the last byte.
    send(8'hAA); send(8'h02); send(8'h10);
    quiet(TO_CYC - 1);
    chk("tmo_not_yet", o_err, 0); chk("tmo_busy_pre", o_busy, 1);
    quiet(1);
    chk("tmo_err", o_err, 1); chk("tmo_code", o_err_code, 3); chk("tmo_busy", o_busy, 0);
    // A byte on the expiry edge wins.
    send(8'hAA); send(8'h02); send(8'h10);
    quiet(TO_CYC - 1);
    send(8'h20);
    chk("tmo_edge_err", o_err, 0); chk("tmo_edge_busy", o_busy, 1);
    send(8'h32);
    chk("tmo_edge_valid", o_frame_valid, 1); peek(0, 8'h10); peek(1, 8'h20);
    cycle(1'b0, 8'h00, 1'b1);

    // Overrun while held, and on the handshake edge.
    send(8'hAA); send(8'h03); send(8'h11); send(8'h22); send(8'h33); send(8'h69);
    send(8'h77);
    chk("ovr_err", o_err, 1); chk("ovr_code", o_err_code, 0); chk("ovr_valid", o_frame_valid, 1);
    peek(0, 8'h11); peek(1, 8'h22); peek(2, 8'h33);
    cycle(1'b1, 8'hAA, 1'b1);
    chk("ovr_hs_err", o_err, 1); chk("ovr_hs_code", o_err_code, 0);
    chk("ovr_hs_valid", o_frame_valid, 0); chk("ovr_hs_busy", o_busy, 0);
    quiet(1);

    // Async reset mid-payload.
    send(8'hAA); send(8'h03); send(8'h11);
    #2 rst_n = 1'b0; #1;
    model_clear();
    chk("arst_busy", o_busy, 0); chk("arst_valid", o_frame_valid, 0);
    chk("arst_len", o_frame_len, 0); chk("arst_err", o_err, 0); peek(0, 0);
    @(negedge clk); @(negedge clk); rst_n = 1'b1;
    send_frame(8'd4, 8'hA8);
    chk("arst_next_valid", o_frame_valid, 1); chk("arst_next_len", o_frame_len, 4);
    peek(2, 8'hAA);
    cycle(1'b0, 8'h00, 1'b1);

    // Randomized stream of mostly-good frames with random gaps and ready.
    for (int f = 0; f < 150; f++) begin
      stream.delete();
      if ($urandom_range(0, 4) == 0) stream.push_back($urandom_range(0, 255));
      stream.push_back(8'hAA);
      case ($urandom_range(0, 9))
        0: l = 8'd0;
        1: l = 8'($urandom_range(17, 255));
        default: l = 8'($urandom_range(1, MAX_LEN));
      endcase
      stream.push_back(l);
      s = l;
      if (l >= 1 && l <= MAX_LEN) begin
        for (int i = 0; i < l; i++) begin
          stream.push_back($urandom_range(0, 255));
          s = s + 8'(stream[stream.size()-1]);
        end
        stream.push_back(($urandom_range(0, 9) == 0) ? 32'(s ^ 8'h01) : 32'(s));
      end
      foreach (stream[k]) begin
        int gap;
        gap = ($urandom_range(0, 40) == 0) ? $urandom_range(TO_CYC - 2, TO_CYC + 1)
                                           : $urandom_range(0, 3);
        for (int g = 0; g < gap; g++) cycle(1'b0, 8'h00, $urandom_range(0, 3) == 0);
        cycle(1'b1, 8'(stream[k]), $urandom_range(0, 3) == 0);
      end
    end
    for (int g = 0; g < 20; g++) cycle(1'b0, 8'h00, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
